// File: rtl/nios2_oci_ram_arbiter.sv
// nios2_oci_ram_arbiter: sequences debugger OCI memory commands and round-robin shares the debug RAM with the CPU
module nios2_oci_ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [37:0]       jdo,
   output logic [DATA_W-1:0] MonDReg,
   output logic              dbg_busy,
   output logic              dbg_overrun,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_write,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_req_ready,
   output logic              cpu_rdata_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] pend_wdata;
   logic pend_valid, pend_write, last_dbg;
   logic grant_cpu, grant_dbg;
   logic accept_a, accept_b, accept_n, drop;
   logic unused_jdo;
   assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};
   assign accept_a = take_action_ocimem_a & ~pend_valid;
   assign accept_b = take_action_ocimem_b & ~take_action_ocimem_a & ~pend_valid;
   assign accept_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b & ~pend_valid;
   assign drop = pend_valid ? (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)
                            : (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                              | (take_action_ocimem_b & take_no_action_ocimem_a);
   assign ram_en = grant_cpu | grant_dbg;
   assign ram_we = grant_cpu ? cpu_req_write : grant_dbg & pend_write;
   assign ram_addr = grant_cpu ? cpu_req_addr : grant_dbg ? dbg_addr : '0;
   assign ram_wdata = (grant_cpu & cpu_req_write) ? cpu_req_wdata : (grant_dbg & pend_write) ? pend_wdata : '0;
   assign cpu_req_ready = grant_cpu;
   assign cpu_rdata_valid = ~reset & (state == CPU_RD);
   assign cpu_rdata = cpu_rdata_valid ? ram_rdata : '0;
   assign dbg_busy = pend_valid | (state == DBG_RD);
   // Arbitrate in IDLE only; a read holds the port for its data-return cycle
   always_comb begin
      grant_cpu = 1'b0;
      grant_dbg = 1'b0;
      state_nxt = IDLE;
      if (!reset && state == IDLE) begin
         grant_cpu = cpu_req_valid & (~pend_valid | last_dbg);
         grant_dbg = pend_valid & ~grant_cpu;
         state_nxt = (grant_cpu & ~cpu_req_write) ? CPU_RD : (grant_dbg & ~pend_write) ? DBG_RD : IDLE;
      end
   end
   // State register
   always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
   // Debugger address, pending command, overrun flag, fairness and readback
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_addr    <= '0;
         pend_valid  <= 1'b0;
         pend_write  <= 1'b0;
         pend_wdata  <= '0;
         dbg_overrun <= 1'b0;
         last_dbg    <= 1'b1;
         MonDReg     <= '0;
      end else begin
         if (accept_a) dbg_addr <= ADDR_W'(jdo[24:17]);
         else if (grant_dbg) dbg_addr <= dbg_addr + ADDR_W'(1);
         if (grant_dbg) pend_valid <= 1'b0;
         else if ((accept_a & jdo[35]) | accept_b | accept_n) begin
            pend_valid <= 1'b1;
            pend_write <= accept_b;
            pend_wdata <= DATA_W'(jdo[34:3]);
         end
         dbg_overrun <= drop | (dbg_overrun & ~accept_a);
         if (grant_cpu | grant_dbg) last_dbg <= grant_dbg;
         if (state == DBG_RD) MonDReg <= ram_rdata;
      end
   end
endmodule

// File: tb/tb_nios2_oci_ram_arbiter.sv
// tb_nios2_oci_ram_arbiter: vector table plus directed sequences against a behavioural RAM
module tb_nios2_oci_ram_arbiter;
   logic clk = 1'b0, reset, a, b, n, cv, cw, ram_clr;
   logic [37:0] jdo;
   logic [7:0] ca;
   logic [31:0] cd;
   logic [31:0] mon, cpu_rdata, ram_wdata, ram_rdata;
   logic busy, ovr, rdy, rv, ram_en, ram_we;
   logic [7:0] ram_addr;
   logic [31:0] mem [256];
   int checks = 0, errors = 0;

   typedef struct {
      logic a, b, n, ra;
      logic [7:0] ja;
      logic [31:0] jw;
      logic cv, cw;
      logic [7:0] ca;
      logic [31:0] cd;
      logic en, we;
      logic [7:0] addr;
      logic [31:0] wd;
      logic rdy, rv;
      logic [31:0] rd, mon;
      logic busy, ovr;
   } vec_t;
   vec_t tbl[$];

   nios2_oci_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .take_action_ocimem_a(a), .take_action_ocimem_b(b), .take_no_action_ocimem_a(n),
      .jdo(jdo), .MonDReg(mon), .dbg_busy(busy), .dbg_overrun(ovr),
      .cpu_req_valid(cv), .cpu_req_write(cw), .cpu_req_addr(ca), .cpu_req_wdata(cd),
      .cpu_req_ready(rdy), .cpu_rdata_valid(rv), .cpu_rdata(cpu_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 1) ? 32'h0BADF00D : 32'h0;
         ram_rdata <= 32'h0;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic set_jdo(input logic ra, input logic [7:0] ja, input logic [31:0] jw, input logic use_ja);
      logic [37:0] j;
      j = {2'b00, ra, jw, 3'b000};
      if (use_ja) j[24:17] = ja;
      jdo = j;
   endtask

   task automatic idle();
      a = 0; b = 0; n = 0; cv = 0; cw = 0; ca = 0; cd = 0; jdo = 0;
   endtask

   initial begin
      idle();
      reset = 1; ram_clr = 1;
      repeat (2) @(negedge clk);
      reset = 0; ram_clr = 0;
      //            a b n ra ja     jw            cv cw ca     cd             en we addr   wd            rdy rv rd            mon           busy ovr
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{1,0,0,0,8'h10,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,1,0,0,8'h00,32'hDEADBEEF, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,1,8'h10,32'hDEADBEEF,  0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{1,0,0,1,8'h10,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,0,8'h10,32'h0,         0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'hDEADBEEF, 0,0});
      tbl.push_back('{0,0,1,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'hDEADBEEF, 0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,1,8'h20,32'h12345678,  1,1,8'h20,32'h12345678,  1,0,32'h0,        32'hDEADBEEF, 1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,0,8'h11,32'h0,         0,0,32'h0,        32'hDEADBEEF, 1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,0,8'h10,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'hDEADBEEF, 1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,0,8'h10,32'h0,         1,0,8'h10,32'h0,         1,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,1,32'hDEADBEEF, 32'h0,        0,0});
      tbl.push_back('{0,0,1,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,1,8'h30,32'hA5A5A5A5,  1,0,8'h12,32'h0,         0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,1,8'h30,32'hA5A5A5A5,  0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        1,1,8'h30,32'hA5A5A5A5,  1,1,8'h30,32'hA5A5A5A5,  1,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{1,0,0,0,8'hFF,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,1,0,0,8'h00,32'h11111111, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,1,0,0,8'h00,32'h22222222, 0,0,8'h00,32'h0,         1,1,8'hFF,32'h11111111,  0,0,32'h0,        32'h0,        1,0});
      tbl.push_back('{0,1,0,0,8'h00,32'h22222222, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,1});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,1,8'h00,32'h22222222,  0,0,32'h0,        32'h0,        1,1});
      tbl.push_back('{1,0,0,0,8'h40,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,1});
      tbl.push_back('{0,1,1,0,8'h00,32'hCAFEF00D, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,0});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,1,8'h40,32'hCAFEF00D,  0,0,32'h0,        32'h0,        1,1});
      tbl.push_back('{1,0,1,1,8'h40,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        0,1});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         1,0,8'h40,32'h0,         0,0,32'h0,        32'h0,        1,1});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'h0,        1,1});
      tbl.push_back('{1,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'hCAFEF00D, 0,1});
      tbl.push_back('{0,0,0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         0,0,32'h0,        32'hCAFEF00D, 0,0});
      foreach (tbl[i]) begin
         @(negedge clk);
         a = tbl[i].a; b = tbl[i].b; n = tbl[i].n;
         set_jdo(tbl[i].ra, tbl[i].ja, tbl[i].jw, tbl[i].a);
         cv = tbl[i].cv; cw = tbl[i].cw; ca = tbl[i].ca; cd = tbl[i].cd;
         #1;
         chk($sformatf("row%0d ram_en", i), {31'b0, ram_en}, {31'b0, tbl[i].en});
         chk($sformatf("row%0d ram_we", i), {31'b0, ram_we}, {31'b0, tbl[i].we});
         chk($sformatf("row%0d ram_addr", i), {24'b0, ram_addr}, {24'b0, tbl[i].addr});
         chk($sformatf("row%0d ram_wdata", i), ram_wdata, tbl[i].wd);
         chk($sformatf("row%0d cpu_req_ready", i), {31'b0, rdy}, {31'b0, tbl[i].rdy});
         chk($sformatf("row%0d cpu_rdata_valid", i), {31'b0, rv}, {31'b0, tbl[i].rv});
         chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, tbl[i].rd);
         chk($sformatf("row%0d MonDReg", i), mon, tbl[i].mon);
         chk($sformatf("row%0d dbg_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
         chk($sformatf("row%0d dbg_overrun", i), {31'b0, ovr}, {31'b0, tbl[i].ovr});
      end
      // Tie after reset: CPU first, then debugger, then CPU again
      @(negedge clk); idle(); reset = 1;
      @(negedge clk); reset = 0; n = 1;
      #1 chk("tie s1 dbg_busy", {31'b0, busy}, 32'h0);
      @(negedge clk); n = 0; cv = 1; cw = 1; ca = 8'h20; cd = 32'h12345678;
      #1 chk("tie s2 cpu_req_ready", {31'b0, rdy}, 32'h1);
      chk("tie s2 ram_addr", {24'b0, ram_addr}, 32'h20);
      chk("tie s2 ram_we", {31'b0, ram_we}, 32'h1);
      @(negedge clk); idle();
      #1 chk("tie s3 ram_en", {31'b0, ram_en}, 32'h1);
      chk("tie s3 ram_we", {31'b0, ram_we}, 32'h0);
      chk("tie s3 ram_addr", {24'b0, ram_addr}, 32'h00);
      chk("tie s3 cpu_req_ready", {31'b0, rdy}, 32'h0);
      @(negedge clk); n = 1; cv = 1; cw = 0; ca = 8'h20;
      #1 chk("tie s4 ram_en", {31'b0, ram_en}, 32'h0);
      chk("tie s4 dbg_busy", {31'b0, busy}, 32'h1);
      @(negedge clk); n = 0;
      #1 chk("tie s5 MonDReg", mon, 32'h22222222);
      chk("tie s5 cpu_req_ready", {31'b0, rdy}, 32'h1);
      chk("tie s5 ram_addr", {24'b0, ram_addr}, 32'h20);
      @(negedge clk); cv = 0;
      #1 chk("tie s6 cpu_rdata_valid", {31'b0, rv}, 32'h1);
      chk("tie s6 cpu_rdata", cpu_rdata, 32'h12345678);
      chk("tie s6 ram_en", {31'b0, ram_en}, 32'h0);
      @(negedge clk);
      #1 chk("tie s7 ram_en", {31'b0, ram_en}, 32'h1);
      chk("tie s7 ram_addr", {24'b0, ram_addr}, 32'h01);
      // Reset while a CPU read is in flight
      @(negedge clk); cv = 1; cw = 0; ca = 8'h20;
      #1 chk("rst s8 ram_en", {31'b0, ram_en}, 32'h0);
      @(negedge clk);
      #1 chk("rst s9 MonDReg", mon, 32'h0BADF00D);
      chk("rst s9 cpu_req_ready", {31'b0, rdy}, 32'h1);
      @(negedge clk); cv = 0; reset = 1;
      @(negedge clk); reset = 0; b = 1; set_jdo(1'b0, 8'h00, 32'h77777777, 1'b0);
      #1 chk("rst s11 cpu_rdata_valid", {31'b0, rv}, 32'h0);
      chk("rst s11 MonDReg", mon, 32'h0);
      chk("rst s11 dbg_busy", {31'b0, busy}, 32'h0);
      chk("rst s11 dbg_overrun", {31'b0, ovr}, 32'h0);
      @(negedge clk); idle();
      #1 chk("rst s12 ram_we", {31'b0, ram_we}, 32'h1);
      chk("rst s12 ram_addr", {24'b0, ram_addr}, 32'h00);
      chk("rst s12 ram_wdata", ram_wdata, 32'h77777777);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nios2_oci_ram_arbiter.md
# nios2_oci_ram_arbiter

Sysclk-domain controller that sequences debugger-issued OCI memory commands (the `take_action_ocimem_*` strobes and `jdo` payload from the JTAG debug module's sysclk side) and shares the single port of the on-chip debug RAM between the debugger and the CPU's debug-mode data master. It owns the debugger's auto-incrementing word address, produces `MonDReg` for readback, and round-robin arbitrates RAM access.

## Interface
- `ADDR_W`, 8, RAM word-address width (256 words)
- `DATA_W`, 32, RAM data width
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `take_action_ocimem_a`  in  1  one-cycle strobe: load debugger address, optional read-ahead
- `take_action_ocimem_b`  in  1  one-cycle strobe: debugger write
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: debugger read
- `jdo`  in  38  command payload: `[24:17]` address, `[35]` read-ahead enable, `[34:3]` write data
- `MonDReg`  out  DATA_W  last debugger read data
- `dbg_busy`  out  1  debugger command pending or in flight
- `dbg_overrun`  out  1  sticky: a debugger strobe was dropped
- `cpu_req_valid`  in  1  CPU request; held until accepted
- `cpu_req_write`  in  1  1 = write, 0 = read
- `cpu_req_addr`  in  ADDR_W  CPU word address
- `cpu_req_wdata`  in  DATA_W  CPU write data
- `cpu_req_ready`  out  1  CPU request accepted this cycle
- `cpu_rdata_valid`  out  1  `cpu_rdata` valid
- `cpu_rdata`  out  DATA_W  CPU read data
- `ram_en`, `ram_we`  out  1  RAM port enable and write enable
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM registered read data, one-cycle latency

## Operation
- Debugger side:
  - Address register `dbg_addr`.
  - One-entry pending register `{valid, write, wdata}`.
- Strobe acceptance:
  - A strobe is accepted only when pending is empty.
  - Multiple strobes in one cycle: priority `ocimem_a` > `ocimem_b` > `no_action` read. Lower-priority strobes are dropped.
  - Any dropped strobe (lost to priority or arriving with pending full) sets `dbg_overrun`.
- Accepted `ocimem_a`:
  - `dbg_addr <= jdo[24:17]`.
  - Clears `dbg_overrun`, unless another strobe is dropped in the same cycle; set wins.
  - If `jdo[35]` is set, also enqueues a read.
- Accepted `ocimem_b` enqueues a write of `jdo[34:3]`.
- Accepted `no_action` enqueues a read.
- Each granted debugger op uses the current `dbg_addr`, then increments it modulo 2^ADDR_W (0xFF → 0x00).
- FSM:
  - States: IDLE, CPU_RD, DBG_RD.
  - Grants occur only in IDLE.
  - A granted write completes in its grant cycle; the FSM stays in IDLE.
  - A granted read moves to CPU_RD or DBG_RD for one cycle, then returns to IDLE.
- Arbitration:
  - Requesters: `cpu_req_valid` and pending valid.
  - Single requester: it wins.
  - Both requesting: the one not granted last wins.
  - `last_grant` resets to debugger, so the CPU wins the first tie.
- Grant cycle drives `ram_*` combinationally from the winner. No `ram_*` activity without a grant.
- CPU grant: `cpu_req_ready = 1` in that cycle.
- DBG_RD cycle: `MonDReg <= ram_rdata`.
- CPU_RD cycle: `cpu_rdata = ram_rdata` and `cpu_rdata_valid = 1`.
- `dbg_busy = pending valid | (state == DBG_RD)`.
- Reset values:
  - State IDLE, pending empty, `dbg_addr = 0`, `MonDReg = 0`, `dbg_overrun = 0`, `last_grant = dbg`.
  - Outputs `ram_en`, `ram_we`, `cpu_req_ready`, `cpu_rdata_valid`, `dbg_busy` all 0.
- Reset mid-operation aborts any read in flight; no `cpu_rdata_valid` or `MonDReg` update follows.

## Timing
- Strobe in cycle T → pending valid from T+1; earliest debugger grant is T+1.
- Read grant in cycle G:
  - `ram_rdata` arrives in G+1.
  - `cpu_rdata_valid` is asserted in G+1.
  - `MonDReg` shows the new value from G+2.
- Throughput: one write per cycle; one read every 2 cycles.
- With both requesters active, grants alternate.
- `cpu_req_*` must stay stable while valid and not ready.
- Address load by `ocimem_a` is visible from T+1; a read-ahead grant at T+1 uses the new address.

## Test plan
- Address load then write:
  - Reset; `ocimem_a` with `jdo[24:17]=0x10`, `jdo[35]=0` → no `ram_en`.
  - Then `ocimem_b` with data 0xDEADBEEF → `ram_we=1`, `ram_addr=0x10`, `ram_wdata=0xDEADBEEF`; `dbg_addr` becomes 0x11.
- Read-ahead: `ocimem_a` with address 0x10, `jdo[35]=1` → RAM read at 0x10; `MonDReg=0xDEADBEEF` at G+2; `dbg_addr=0x11`; `dbg_busy` deasserts at G+2.
- Tie after reset: `cpu_req_valid` write to 0x20 with 0x12345678, and debugger read pending in the same cycle → CPU granted first (`cpu_req_ready=1`); debugger granted the next cycle; a further tie grants CPU.
- Address wrap: `dbg_addr` loaded to 0xFF, then write → `ram_addr=0xFF`; next write → `ram_addr=0x00`.
- Overrun:
  - `ocimem_b` and `no_action` in the same cycle → write executes, read is dropped, `dbg_overrun=1`.
  - A strobe while pending is full also sets it.
  - The next accepted `ocimem_a` clears it.
- Reset mid-read: `reset` asserted in a CPU_RD cycle → state IDLE next cycle, `cpu_rdata_valid=0`, `MonDReg=0`, `dbg_addr=0`.
